coreaxitoahbl_rw_arbiter: RTL and testbench
===========================================

COREAXITOAHBL_RW_ARBITER -- requirements
Module: coreaxitoahbl_rw_arbiter

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, giving the width of the AXI ID fields.
REQ-002 The block SHALL have parameter TIMEOUT, default 256, giving the maximum number of cycles a granted transfer may stay busy (legal range 2..65535).
REQ-003 The block SHALL have one clock and one reset: ACLK  input  1  clock, all logic on the rising edge.
REQ-004 ARESETN  input  1  reset, synchronous, active-low.
REQ-005 AWVALID  input  1  AXI write address request pending.
REQ-006 AWID  input  ID_WIDTH  write transaction ID.
REQ-007 ARVALID  input  1  AXI read address request pending.
REQ-008 ARID  input  ID_WIDTH  read transaction ID.
REQ-009 xferDone  input  1  single-cycle pulse from the AHB-Lite master control: the granted transfer is complete.
REQ-010 AWREADYOut  output  1  registered one-cycle accept pulse for the write address; feeds the AXI output register stage.
REQ-011 ARREADYOut  output  1  registered one-cycle accept pulse for the read address; feeds the AXI output register stage.
REQ-012 wrGrant  output  1  the shared AHB-Lite master is owned by a write.
REQ-013 rdGrant  output  1  the shared AHB-Lite master is owned by a read.
REQ-014 grantID  output  ID_WIDTH  ID captured at acceptance; held stable while a grant is active.
REQ-015 timeoutErr  output  1  one-cycle pulse: the granted transfer exceeded TIMEOUT.

Function
REQ-016 The block SHALL implement the states IDLE, WR_BUSY and RD_BUSY. Exactly one state is active at a time.
REQ-017 In IDLE with AWVALID=1 and ARVALID=0, the block SHALL move to WR_BUSY on the next edge.
- On that edge: AWREADYOut=1 for that one cycle, grantID<=AWID, lastWr<=1.
REQ-018 In IDLE with ARVALID=1 and AWVALID=0, the block SHALL move to RD_BUSY on the next edge.
- On that edge: ARREADYOut=1 for that one cycle, grantID<=ARID, lastWr<=0.
REQ-019 In IDLE with both requests set, the block SHALL use round-robin arbitration.
- Grant read if lastWr=1; grant write if lastWr=0.
- Acceptance as in REQ-017/018.
REQ-020 The block SHALL drive wrGrant=1 exactly while in WR_BUSY and rdGrant=1 exactly while in RD_BUSY.
- wrGrant and rdGrant are never both 1.
REQ-021 AWREADYOut and ARREADYOut SHALL never both be 1.
- Each SHALL be 1 for exactly one cycle per accepted request: the first cycle of the corresponding BUSY state.
REQ-022 In a BUSY state, xferDone=1 SHALL return the block to IDLE on the next edge.
- grantID holds its value in IDLE until the next acceptance.
REQ-023 Minimum request-to-request spacing SHALL be one IDLE cycle.
- A new acceptance never occurs on the edge that leaves BUSY.
REQ-024 The block SHALL use a busy counter, width clog2(TIMEOUT).
- Cleared on entry to a BUSY state.
- Increments each BUSY cycle without xferDone.
- Does not wrap.
REQ-025 If the counter equals TIMEOUT-1 in a BUSY state and xferDone=0, the block SHALL pulse timeoutErr=1 for one cycle and return to IDLE on the next edge.
REQ-026 If xferDone=1 on the same cycle the counter reaches TIMEOUT-1, the completion SHALL win: no timeoutErr, normal return to IDLE.
REQ-027 xferDone in IDLE SHALL be ignored (no state or output change).
REQ-028 Requests deasserting while the block is BUSY SHALL have no effect.
- Arbitration samples AWVALID/ARVALID only in IDLE.

Reset
REQ-029 When ARESETN=0 at a rising edge, the block SHALL load the following reset values:
- state IDLE, lastWr=0, counter 0.
- AWREADYOut, ARREADYOut, wrGrant, rdGrant, timeoutErr = 0.
- grantID = 0.
REQ-030 Reset asserted mid-transfer SHALL abort the grant on that edge, without a timeoutErr pulse.
REQ-031 After reset, the first contended arbitration SHALL grant write.

Verification
REQ-032 Reset release, then AWVALID=1 AWID=4'h3 ARVALID=0 -> next cycle AWREADYOut=1 (one cycle), wrGrant=1, grantID=3; xferDone pulse -> IDLE, wrGrant=0.
REQ-033 After reset, AWVALID=ARVALID=1 held, AWID=1, ARID=2, xferDone 3 cycles after each grant -> grant order write(1), read(2), write(1), read(2); one idle cycle between grants.
REQ-034 TIMEOUT=8, read granted, xferDone never asserted -> timeoutErr pulses on the 8th RD_BUSY cycle, IDLE next cycle, rdGrant=0.
REQ-035 TIMEOUT=8, xferDone on the 8th BUSY cycle -> no timeoutErr, normal return to IDLE.
REQ-036 ARESETN=0 during WR_BUSY -> all outputs 0 next edge; after release, contended requests grant write first.
REQ-037 Continuous assertion checks: wrGrant&rdGrant never 1; AWREADYOut&ARREADYOut never 1; each READY pulse width exactly 1; grantID stable throughout a grant.

Source files
------------

// File: rtl/coreaxitoahbl_rw_arbiter_if.sv
// Request/grant bundle between the AXI slave front end and the
// read/write arbiter of the AXI-to-AHB-Lite bridge.
// master: drives AW/AR requests and xferDone; slave: the arbiter.
interface coreaxitoahbl_rw_arbiter_if #(
  parameter int ID_WIDTH = 4
);
  logic                AWVALID;
  logic [ID_WIDTH-1:0] AWID;
  logic                ARVALID;
  logic [ID_WIDTH-1:0] ARID;
  logic                xferDone;
  logic                AWREADYOut;
  logic                ARREADYOut;
  logic                wrGrant;
  logic                rdGrant;
  logic [ID_WIDTH-1:0] grantID;
  logic                timeoutErr;

  modport master (
    output AWVALID, AWID, ARVALID, ARID, xferDone,
    input  AWREADYOut, ARREADYOut, wrGrant, rdGrant,
    input  grantID, timeoutErr
  );

  modport slave (
    input  AWVALID, AWID, ARVALID, ARID, xferDone,
    output AWREADYOut, ARREADYOut, wrGrant, rdGrant,
    output grantID, timeoutErr
  );
endinterface

// File: rtl/coreaxitoahbl_rw_arbiter.sv
// Round-robin read/write arbiter owning the shared AHB-Lite master.
// Ports: ACLK, ARESETN (sync, active-low), bus (slave modport).
module coreaxitoahbl_rw_arbiter #(
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  coreaxitoahbl_rw_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nstate;
  logic                r_lastWr;
  logic [CW-1:0]       r_cnt;
  logic [ID_WIDTH-1:0] r_grantID;
  logic                r_awready;
  logic                r_arready;
  logic                w_accWr;
  logic                w_accRd;
  logic                w_tmo;
  logic                w_busy;

  assign w_busy = (r_state != IDLE);

  always_comb begin
    w_nstate = r_state;
    w_accWr  = 1'b0;
    w_accRd  = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // contended: alternate against the last winner
        if (bus.AWVALID && (!bus.ARVALID || !r_lastWr)) begin
          w_nstate = WR_BUSY;
          w_accWr  = 1'b1;
        end else if (bus.ARVALID) begin
          w_nstate = RD_BUSY;
          w_accRd  = 1'b1;
        end
      end
      WR_BUSY, RD_BUSY: begin
        // completion beats timeout on the same cycle
        if (bus.xferDone) begin
          w_nstate = IDLE;
        end else if (r_cnt == CMAX) begin
          w_nstate = IDLE;
          w_tmo    = 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_lastWr  <= 1'b0;
      r_cnt     <= '0;
      r_grantID <= '0;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_awready <= w_accWr;
      r_arready <= w_accRd;
      if (w_accWr) begin
        r_grantID <= bus.AWID;
        r_lastWr  <= 1'b1;
        r_cnt     <= '0;
      end else if (w_accRd) begin
        r_grantID <= bus.ARID;
        r_lastWr  <= 1'b0;
        r_cnt     <= '0;
      end else if (w_busy && !bus.xferDone
                   && r_cnt != CMAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.AWREADYOut = r_awready;
  assign bus.ARREADYOut = r_arready;
  assign bus.wrGrant    = (r_state == WR_BUSY);
  assign bus.rdGrant    = (r_state == RD_BUSY);
  assign bus.grantID    = r_grantID;
  // gated by reset so an aborted grant never reports a timeout
  assign bus.timeoutErr = ARESETN & w_tmo;

endmodule

// File: tb/tb_coreaxitoahbl_rw_arbiter.sv
// Bench for coreaxitoahbl_rw_arbiter: cycle vector table,
// grant-order scoreboard and continuous invariant checks.
module tb_coreaxitoahbl_rw_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  coreaxitoahbl_rw_arbiter_if #(.ID_WIDTH(4)) bus();

  coreaxitoahbl_rw_arbiter #(
    .ID_WIDTH(4),
    .TIMEOUT (8)
  ) u_dut (
    .ACLK   (clk),
    .ARESETN(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       awv;
    logic [3:0] awid;
    logic       arv;
    logic [3:0] arid;
    logic       done;
    logic       e_tmo;
    logic       e_wg;
    logic       e_rg;
    logic       e_awr;
    logic       e_arr;
    logic [3:0] e_id;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [3:0] id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic v(input logic r, input logic aw, input logic [3:0] awid,
                   input logic ar, input logic [3:0] arid, input logic d,
                   input logic t, input logic wg, input logic rg,
                   input logic awr, input logic arr, input logic [3:0] id);
    vec_t x;
    x.rst_n = r; x.awv = aw; x.awid = awid; x.arv = ar; x.arid = arid;
    x.done = d; x.e_tmo = t; x.e_wg = wg; x.e_rg = rg;
    x.e_awr = awr; x.e_arr = arr; x.e_id = id;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic aw, input logic [3:0] awid,
                       input logic ar, input logic [3:0] arid,
                       input logic d);
    bus.AWVALID = aw; bus.AWID = awid;
    bus.ARVALID = ar; bus.ARID = arid;
    bus.xferDone = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // invariants, sampled on the falling edge
  logic       p_awr = 1'b0, p_arr = 1'b0, p_wg = 1'b0, p_rg = 1'b0;
  logic [3:0] p_id = 4'h0;
  always @(negedge clk) begin
    tests++;
    if (bus.wrGrant && bus.rdGrant) begin
      fails++;
      $display("FAIL both_grants wr=%b rd=%b required not both 1",
               bus.wrGrant, bus.rdGrant);
    end
    tests++;
    if (bus.AWREADYOut && bus.ARREADYOut) begin
      fails++;
      $display("FAIL both_ready aw=%b ar=%b required not both 1",
               bus.AWREADYOut, bus.ARREADYOut);
    end
    if (p_awr || p_arr) begin
      tests++;
      if ((p_awr && bus.AWREADYOut) || (p_arr && bus.ARREADYOut)) begin
        fails++;
        $display("FAIL ready_width aw=%b ar=%b required 0 after pulse",
                 bus.AWREADYOut, bus.ARREADYOut);
      end
    end
    if ((p_wg && bus.wrGrant) || (p_rg && bus.rdGrant)) begin
      tests++;
      if (bus.grantID !== p_id) begin
        fails++;
        $display("FAIL id_stable got=%h required=%h", bus.grantID, p_id);
      end
    end
    p_awr = bus.AWREADYOut; p_arr = bus.ARREADYOut;
    p_wg = bus.wrGrant; p_rg = bus.rdGrant; p_id = bus.grantID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t got;
    int   waits;
    logic rdy;

    drive(0, 0, 0, 0, 0);

    // reset
    v(0,0,0,0,0,0, 0,0,0,0,0,0);
    v(0,0,0,0,0,0, 0,0,0,0,0,0);
    // single write id 3, then done
    v(1,1,3,0,0,0, 0,1,0,1,0,3);
    v(1,0,0,0,0,0, 0,1,0,0,0,3);
    v(1,0,0,0,0,1, 0,0,0,0,0,3);
    // xferDone in IDLE ignored
    v(1,0,0,0,0,1, 0,0,0,0,0,3);
    // single read id 5
    v(1,0,0,1,5,0, 0,0,1,0,1,5);
    v(1,0,0,0,0,0, 0,0,1,0,0,5);
    v(1,0,0,0,0,1, 0,0,0,0,0,5);
    // contended, last was read -> write; requests drop while busy
    v(1,1,9,1,10,0, 0,1,0,1,0,9);
    v(1,0,0,0,0,0, 0,1,0,0,0,9);
    v(1,0,0,0,0,1, 0,0,0,0,0,9);
    // contended, last was write -> read; then timeout
    v(1,1,7,1,6,0, 0,0,1,0,1,6);
    for (int k = 0; k < 7; k++) v(1,0,0,0,0,0, 0,0,1,0,0,6);
    v(1,0,0,0,0,0, 1,0,0,0,0,6);
    v(1,0,0,0,0,0, 0,0,0,0,0,6);
    // write with xferDone on the 8th busy cycle: no timeout
    v(1,1,10,0,0,0, 0,1,0,1,0,10);
    for (int k = 0; k < 7; k++) v(1,0,0,0,0,0, 0,1,0,0,0,10);
    v(1,0,0,0,0,1, 0,0,0,0,0,10);
    v(1,0,0,0,0,0, 0,0,0,0,0,10);
    // reset during WR_BUSY, then contended -> write first
    v(1,1,12,0,0,0, 0,1,0,1,0,12);
    v(1,0,0,0,0,0, 0,1,0,0,0,12);
    v(0,0,0,0,0,0, 0,0,0,0,0,0);
    v(1,1,1,1,2,0, 0,1,0,1,0,1);
    v(1,0,0,0,0,1, 0,0,0,0,0,1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      drive(tbl[i].awv, tbl[i].awid, tbl[i].arv, tbl[i].arid, tbl[i].done);
      #1;
      tests++;
      if (bus.timeoutErr !== tbl[i].e_tmo) begin
        fails++;
        $display("FAIL row%0d_tmo got=%b required=%b",
                 i, bus.timeoutErr, tbl[i].e_tmo);
      end
      cyc();
      tests++;
      if ({bus.wrGrant, bus.rdGrant, bus.AWREADYOut, bus.ARREADYOut,
           bus.grantID} !==
          {tbl[i].e_wg, tbl[i].e_rg, tbl[i].e_awr, tbl[i].e_arr,
           tbl[i].e_id}) begin
        fails++;
        $display("FAIL row%0d_out got wg=%b rg=%b awr=%b arr=%b id=%h required wg=%b rg=%b awr=%b arr=%b id=%h",
                 i, bus.wrGrant, bus.rdGrant, bus.AWREADYOut,
                 bus.ARREADYOut, bus.grantID, tbl[i].e_wg, tbl[i].e_rg,
                 tbl[i].e_awr, tbl[i].e_arr, tbl[i].e_id);
      end
    end

    // round-robin sequence with requests held after reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    cyc();
    cyc();
    e.wr = 1'b1; e.id = 4'h1; sb.push_back(e);
    e.wr = 1'b0; e.id = 4'h2; sb.push_back(e);
    e.wr = 1'b1; e.id = 4'h1; sb.push_back(e);
    e.wr = 1'b0; e.id = 4'h2; sb.push_back(e);
    rst_n = 1'b1;
    drive(1, 4'h1, 1, 4'h2, 0);

    for (int g = 0; g < 4; g++) begin
      waits = 0;
      rdy = 1'b0;
      while (!rdy && waits < 10) begin
        cyc();
        waits++;
        rdy = bus.AWREADYOut | bus.ARREADYOut;
      end
      tests++;
      if (!rdy) begin
        fails++;
        $display("FAIL rr_grant%0d_timeout got=no_ready required=ready", g);
        break;
      end
      e = sb.pop_front();
      got.wr = bus.AWREADYOut;
      got.id = bus.grantID;
      tests++;
      if (got.wr !== e.wr || got.id !== e.id || bus.wrGrant !== e.wr
          || bus.rdGrant !== !e.wr) begin
        fails++;
        $display("FAIL rr_grant%0d got wr=%b id=%h required wr=%b id=%h",
                 g, got.wr, got.id, e.wr, e.id);
      end
      if (g > 0) begin
        tests++;
        if (waits != 1) begin
          fails++;
          $display("FAIL rr_gap%0d got=%0d required=1 idle cycle",
                   g, waits);
        end
      end
      cyc();
      cyc();
      bus.xferDone = 1'b1;
      cyc();
      bus.xferDone = 1'b0;
      tests++;
      if (bus.wrGrant || bus.rdGrant) begin
        fails++;
        $display("FAIL rr_idle%0d got wg=%b rg=%b required 0 0",
                 g, bus.wrGrant, bus.rdGrant);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rr_leftover got=%0d required=0", sb.size());
    end

    drive(0, 0, 0, 0, 0);
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
